// File: rtl/vgabrew_timing_pkg.sv
// Shared timing constants and types for the SXGA (1280x1024 @ 60 Hz,
// 108 MHz pixel clock) timing generator.
//
// Contents:
//   - CNT_W           : width of the h/v counters and of the x/y outputs
//   - SXGA_*          : default horizontal/vertical active, porch and sync widths
//   - SXGA_H_TOTAL    : pixels per line (1688)
//   - SXGA_V_TOTAL    : lines per frame (1066)
//   - LOCK_SETTLE_DEF : default number of consecutive locked cycles before output
//   - tg_state_e      : FSM state encoding (WAIT_LOCK, SETTLE, RUN)
package vgabrew_timing_pkg;

    localparam int CNT_W = 11;

    localparam int SXGA_H_ACTIVE = 1280;
    localparam int SXGA_H_FP     = 48;
    localparam int SXGA_H_SYNC   = 112;
    localparam int SXGA_H_BP     = 248;
    localparam int SXGA_H_TOTAL  = SXGA_H_ACTIVE + SXGA_H_FP + SXGA_H_SYNC + SXGA_H_BP;

    localparam int SXGA_V_ACTIVE = 1024;
    localparam int SXGA_V_FP     = 1;
    localparam int SXGA_V_SYNC   = 3;
    localparam int SXGA_V_BP     = 38;
    localparam int SXGA_V_TOTAL  = SXGA_V_ACTIVE + SXGA_V_FP + SXGA_V_SYNC + SXGA_V_BP;

    localparam int LOCK_SETTLE_DEF = 1024;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_RUN       = 2'd2
    } tg_state_e;

endpackage

// File: rtl/lock_qualifier.sv
// Lock qualifier: brings the asynchronous PLL lock into the pixel clock
// domain and counts how long it has been stable.
//
// Ports:
//   clk       in   pixel clock
//   rst       in   synchronous active-high reset (clears synchronizer and counter)
//   locked    in   raw PLL lock status (asynchronous)
//   settle_en in   high while the parent FSM is in SETTLE; counting only happens then
//   lock_s    out  lock after the 2-flop synchronizer
//   lock_ok   out  combinational: settle count has reached LOCK_SETTLE-1 with lock_s=1
module lock_qualifier #(
    parameter int LOCK_SETTLE = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic locked,
    input  logic settle_en,
    output logic lock_s,
    output logic lock_ok
);

    localparam int SW = $clog2(LOCK_SETTLE + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_SETTLE - 1);

    logic [1:0]    sync_q, sync_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;

    assign lock_s  = sync_q[1];
    assign lock_ok = settle_en && lock_s && (settle_cnt_q == SETTLE_LAST);

    always_comb begin
        sync_d       = {sync_q[0], locked};
        // Any cycle outside SETTLE, or any lock drop, restarts the full count.
        settle_cnt_d = '0;
        if (settle_en && lock_s && (settle_cnt_q != SETTLE_LAST)) begin
            settle_cnt_d = settle_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            settle_cnt_q <= '0;
        end else begin
            sync_q       <= sync_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

endmodule

// File: rtl/sxga_timing_gen.sv
// SXGA video timing generator. Waits for a qualified PLL lock, then runs
// free h/v counters and emits registered sync/enable/coordinate decodes.
//
// Optional feature: define VGABREW_FRAME_CNT_EN to add a 16-bit frame_cnt
// output that counts frame_start pulses (cleared by reset and lock loss).
//
// Ports:
//   refclk      in   pixel clock (108 MHz from PLL outclk_0)
//   rst         in   synchronous active-high reset
//   locked      in   PLL lock (asynchronous)
//   hsync       out  horizontal sync, active-high
//   vsync       out  vertical sync, active-high
//   de          out  data enable, high in the active area only
//   x, y        out  pixel column/row while de=1, 0 otherwise
//   line_start  out  one-cycle pulse at h=0 of each line (RUN only)
//   frame_start out  one-cycle pulse at h=0, v=0 (RUN only)
//   frame_cnt   out  frame counter (only with VGABREW_FRAME_CNT_EN)
//   dbg_state   out  current FSM state
module sxga_timing_gen
    import vgabrew_timing_pkg::*;
#(
    parameter int H_ACTIVE    = SXGA_H_ACTIVE,
    parameter int H_FP        = SXGA_H_FP,
    parameter int H_SYNC      = SXGA_H_SYNC,
    parameter int H_BP        = SXGA_H_BP,
    parameter int V_ACTIVE    = SXGA_V_ACTIVE,
    parameter int V_FP        = SXGA_V_FP,
    parameter int V_SYNC      = SXGA_V_SYNC,
    parameter int V_BP        = SXGA_V_BP,
    parameter int LOCK_SETTLE = LOCK_SETTLE_DEF
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start,
`ifdef VGABREW_FRAME_CNT_EN
    output logic [15:0]      frame_cnt,
`endif
    output tg_state_e        dbg_state
);

    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    tg_state_e        state_q, state_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             lock_s, lock_ok;
    logic             out_en;

    lock_qualifier #(
        .LOCK_SETTLE (LOCK_SETTLE)
    ) u_lock_qualifier (
        .clk       (refclk),
        .rst       (rst),
        .locked    (locked),
        .settle_en (state_q == ST_SETTLE),
        .lock_s    (lock_s),
        .lock_ok   (lock_ok)
    );

    // Gating with lock_s makes the outputs drop in the same edge that the
    // FSM leaves RUN, instead of decoding one more stale position.
    assign out_en = (state_q == ST_RUN) && lock_s;

    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (lock_s) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!lock_s)      state_d = ST_WAIT_LOCK;
                else if (lock_ok) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    h_cnt_d = '0;
                    v_cnt_d = '0;
                end else if (h_cnt_q == H_LAST) begin
                    h_cnt_d = '0;
                    v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
                end else begin
                    h_cnt_d = h_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_WAIT_LOCK;
        endcase
    end

    always_comb begin
        de_d          = out_en && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        x_d           = de_d ? h_cnt_q : '0;
        y_d           = de_d ? v_cnt_q : '0;
        hsync_d       = out_en && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        vsync_d       = out_en && (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
        line_start_d  = out_en && (h_cnt_q == '0);
        frame_start_d = line_start_d && (v_cnt_q == '0);
    end

`ifdef VGABREW_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Counts with frame_start_d so the new value appears alongside the pulse.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (!out_en)            frame_cnt_d = '0;
        else if (frame_start_d) frame_cnt_d = frame_cnt_q + 16'd1;
    end

    always_ff @(posedge refclk) begin
        if (rst) frame_cnt_q <= '0;
        else     frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`endif

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q       <= ST_WAIT_LOCK;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/sxga_timing_gen.md
SXGA_TIMING_GEN -- requirements
Module: sxga_timing_gen

Interface
- REQ-001: Parameter H_ACTIVE, default 1280, visible pixels per line.
- REQ-002: Parameter H_FP / H_SYNC / H_BP, defaults 48 / 112 / 248, horizontal porch and sync widths in pixels; line total 1688.
- REQ-003: Parameter V_ACTIVE, default 1024, visible lines per frame.
- REQ-004: Parameter V_FP / V_SYNC / V_BP, defaults 1 / 3 / 38, vertical porch and sync widths in lines; frame total 1066.
- REQ-005: Parameter LOCK_SETTLE, default 1024, consecutive locked cycles required before output starts.
- REQ-006: refclk  input  1  pixel clock, 108 MHz, driven from the PLL outclk_0; the single clock of the block.
- REQ-007: rst  input  1  reset, synchronous, active-high.
- REQ-008: locked  input  1  PLL lock status; treated as asynchronous and passed through a 2-flop synchronizer.
- REQ-009: hsync  output  1  horizontal sync, active-high.
- REQ-010: vsync  output  1  vertical sync, active-high.
- REQ-011: de  output  1  data enable; high only in the active area.
- REQ-012: x  output  11  pixel column, 0..H_ACTIVE-1 while de=1, held at 0 otherwise.
- REQ-013: y  output  11  pixel row, 0..V_ACTIVE-1 while de=1, held at 0 otherwise.
- REQ-014: line_start  output  1  one-cycle pulse at h=0 of every line, in RUN only.
- REQ-015: frame_start  output  1  one-cycle pulse at h=0, v=0, in RUN only.

Function
- REQ-016: The FSM shall have three states: WAIT_LOCK, SETTLE and RUN.
- REQ-017: WAIT_LOCK -> SETTLE when the synchronized lock is 1.
- REQ-018: In SETTLE, a settle counter shall increment while lock=1; any lock=0 returns the FSM to WAIT_LOCK and clears the counter.
- REQ-019: SETTLE -> RUN when the settle counter reaches LOCK_SETTLE-1 with lock=1.
- REQ-020: RUN -> WAIT_LOCK in the cycle after the synchronized lock reads 0; the counters clear and all outputs return to their reset values.
- REQ-021: In RUN, h_cnt shall count 0..1687 and wrap to 0; v_cnt shall increment on each h wrap and wrap 1065 -> 0.
- REQ-022: Outputs shall be registered decodes of (h_cnt, v_cnt) with one cycle of latency, all mutually aligned.
- REQ-023: de = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
- REQ-024: hsync = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [1328, 1440).
- REQ-025: vsync = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. [1025, 1028), over full lines.
- REQ-026: The first output cycle after entering RUN shall present h=0, v=0: frame_start=1, line_start=1, de=1, x=0, y=0.
- REQ-027: All comparisons shall be unsigned; counters shall be 11 bits wide and shall never exceed their totals.

Reset
- REQ-028: rst=1 at a rising edge of refclk shall force WAIT_LOCK, clear the settle counter, h_cnt, v_cnt and the synchronizer, and drive hsync, vsync, de, line_start and frame_start to 0 and x, y to 0 on the next cycle.
- REQ-029: Reset mid-frame shall take effect immediately, with no completion of the current line.

Configuration
- REQ-030: With VGABREW_FRAME_CNT_EN defined, the block shall add an output frame_cnt (16 bits) that increments on each frame_start, wraps at 65535 -> 0, and clears on reset or on lock loss.
- REQ-031: With VGABREW_FRAME_CNT_EN undefined, the frame_cnt port and its logic shall not exist.

Structure
- REQ-032: Package vgabrew_timing_pkg shall hold the SXGA timing constants, the line and frame totals, and the FSM state enum typedef.
- REQ-033: The lock synchronizer and settle counter shall be a sub-module named lock_qualifier, with output lock_ok.

Verification
- REQ-034: Scenario 1: locked=1 from reset release -> frame_start first high exactly 2+LOCK_SETTLE+1 cycles later (sync + settle + output latency); x=0, y=0, de=1 in that cycle.
- REQ-035: Scenario 2: run 2 full frames -> 1688*1066 = 1,799,408 cycles between frame_starts; 1,310,720 de cycles per frame; hsync 112 cycles wide per line.
- REQ-036: Scenario 3: sample at line 1025 -> vsync rises together with line_start; vsync stays high for 3*1688 = 5064 cycles.
- REQ-037: Scenario 4: glitch locked low for 1 cycle at settle count 500 -> FSM returns to WAIT_LOCK; the full LOCK_SETTLE count restarts.
- REQ-038: Scenario 5: drop locked at h=600, v=300 in RUN -> within 3 cycles all outputs are 0; after relock, restart from h=0, v=0.
- REQ-039: Scenario 6: with VGABREW_FRAME_CNT_EN defined, assert rst mid-frame with frame_cnt=5 -> next cycle all outputs are 0, frame_cnt=0, FSM in WAIT_LOCK.
